if_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 32 +++
 rtl/pc_next_sel.sv | 89 ++++++++
 rtl/if_stage.sv | 119 +++++++++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, fetch FSM states and next-PC select encodings
package cpu_pkg;

   localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
   localparam logic [31:0] RESET_PC          = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'h1000_FFFF;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   // Redirect priority, highest first: branch, jump, hold (stall/halt), sequential.
   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_HOLD   = 2'd1,
      SEL_JUMP   = 2'd2,
      SEL_BRANCH = 2'd3
   } pc_sel_e;

   typedef enum logic [1:0] {
      IFID_HOLD   = 2'd0,
      IFID_LOAD   = 2'd1,
      IFID_BUBBLE = 2'd2
   } ifid_op_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC, IF/ID load/bubble and next-state selector
module pc_next_sel
   import cpu_pkg::*;
#(
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  fetch_state_e state_i,
   input  logic [31:0]  pc_i,
   input  logic [31:0]  imem_data_i,
   input  logic         stall_i,
   input  logic         jump_valid_i,
   input  logic [31:0]  jump_target_i,
   input  logic         br_taken_i,
   input  logic [31:0]  br_target_i,
   output logic [31:0]  pc_next_o,
   output logic [31:0]  pc_plus4_o,
   output ifid_op_e     ifid_op_o,
   output fetch_state_e state_next_o,
   output logic         stall_hold_o,
   output logic         redirect_o
);

   pc_sel_e sel;

   assign pc_plus4_o = pc_i + 32'd4;

   always_comb begin
      sel          = SEL_HOLD;
      ifid_op_o    = IFID_HOLD;
      state_next_o = state_i;
      stall_hold_o = 1'b0;
      redirect_o   = 1'b0;
      case (state_i)
         ST_BOOT: begin
            ifid_op_o    = IFID_BUBBLE;
            state_next_o = ST_RUN;
         end
         ST_RUN: begin
            if (br_taken_i) begin
               sel        = SEL_BRANCH;
               ifid_op_o  = IFID_BUBBLE;
               redirect_o = 1'b1;
            end else if (jump_valid_i) begin
               sel        = SEL_JUMP;
               ifid_op_o  = IFID_BUBBLE;
               redirect_o = 1'b1;
            end else if (stall_i) begin
               stall_hold_o = 1'b1;
            end else begin
               ifid_op_o = IFID_LOAD;
               // The halt word is still handed to ID; only the PC parks.
               if (imem_data_i == HALT_WORD) begin
                  state_next_o = ST_HALTED;
               end else begin
                  sel = SEL_SEQ;
               end
            end
         end
         ST_HALTED: begin
            ifid_op_o = IFID_BUBBLE;
            if (br_taken_i) begin
               sel          = SEL_BRANCH;
               redirect_o   = 1'b1;
               state_next_o = ST_RUN;
            end else if (jump_valid_i) begin
               sel          = SEL_JUMP;
               redirect_o   = 1'b1;
               state_next_o = ST_RUN;
            end
         end
         default: begin
            ifid_op_o    = IFID_BUBBLE;
            state_next_o = ST_BOOT;
         end
      endcase
   end

   always_comb begin
      pc_next_o = pc_i;
      case (sel)
         SEL_SEQ:    pc_next_o = pc_plus4_o;
         SEL_HOLD:   pc_next_o = pc_i;
         SEL_JUMP:   pc_next_o = word_align(jump_target_i);
         SEL_BRANCH: pc_next_o = word_align(br_target_i);
         default:    pc_next_o = pc_i;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS fetch stage: PC, IF/ID register, halt FSM; FETCH_PERF_EN adds counters
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC_P  = RESET_PC,
   parameter logic [31:0] HALT_WORD   = HALT_WORD_DEFAULT,
   parameter logic [31:0] NOP_WORD_P  = NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   input  logic        stall,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] pc,
   output logic [31:0] id_ins,
   output logic [31:0] id_pcp4,
   output logic        id_valid,
   output logic        kill_idex,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetch,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush,
`endif
   output logic        halted
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ins_q;
   logic [31:0]  pcp4_q;
   logic         valid_q;
   logic [31:0]  pc_plus4;
   ifid_op_e     ifid_op;
   logic         stall_hold;
   logic         redirect;

   pc_next_sel #(
      .HALT_WORD (HALT_WORD)
   ) u_pc_next_sel (
      .state_i       (state_q),
      .pc_i          (pc_q),
      .imem_data_i   (imem_data),
      .stall_i       (stall),
      .jump_valid_i  (jump_valid),
      .jump_target_i (jump_target),
      .br_taken_i    (br_taken),
      .br_target_i   (br_target),
      .pc_next_o     (pc_d),
      .pc_plus4_o    (pc_plus4),
      .ifid_op_o     (ifid_op),
      .state_next_o  (state_d),
      .stall_hold_o  (stall_hold),
      .redirect_o    (redirect)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC_P;
         ins_q   <= NOP_WORD_P;
         pcp4_q  <= 32'd0;
         valid_q <= 1'b0;
      end else if (step) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         case (ifid_op)
            IFID_LOAD: begin
               ins_q   <= imem_data;
               pcp4_q  <= pc_plus4;
               valid_q <= 1'b1;
            end
            IFID_BUBBLE: begin
               ins_q   <= NOP_WORD_P;
               pcp4_q  <= 32'd0;
               valid_q <= 1'b0;
            end
            default: begin
               ins_q   <= ins_q;
               pcp4_q  <= pcp4_q;
               valid_q <= valid_q;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_stall_q, perf_flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_q <= 32'd0;
         perf_stall_q <= 32'd0;
         perf_flush_q <= 32'd0;
      end else if (step) begin
         if (ifid_op == IFID_LOAD) perf_fetch_q <= perf_fetch_q + 32'd1;
         if (stall_hold)           perf_stall_q <= perf_stall_q + 32'd1;
         if (redirect)             perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_fetch = perf_fetch_q;
   assign perf_stall = perf_stall_q;
   assign perf_flush = perf_flush_q;
`endif

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign id_ins    = ins_q;
   assign id_pcp4   = pcp4_q;
   assign id_valid  = valid_q;
   assign halted    = (state_q == ST_HALTED);
   assign kill_idex = step & br_taken;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage (FETCH_PERF_EN optional)
module tb_if_stage;

   localparam logic [31:0] HALT = 32'h1000_FFFF;

   logic        clk = 1'b0;
   logic        reset, step, stall, jump_valid, br_taken;
   logic [31:0] jump_target, br_target;
   logic [31:0] imem_addr, imem_data, pc, id_ins, id_pcp4;
   logic        id_valid, kill_idex, halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   if_stage dut (
      .clk         (clk),
      .reset       (reset),
      .step        (step),
      .stall       (stall),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .pc          (pc),
      .id_ins      (id_ins),
      .id_pcp4     (id_pcp4),
      .id_valid    (id_valid),
      .kill_idex   (kill_idex),
`ifdef FETCH_PERF_EN
      .perf_fetch  (perf_fetch),
      .perf_stall  (perf_stall),
      .perf_flush  (perf_flush),
`endif
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // Instruction memory: a fixed word at 0, the halt word at 0x20, address-tagged filler elsewhere.
   always_comb begin
      if (imem_addr == 32'h0)       imem_data = 32'h2008_0005;
      else if (imem_addr == 32'h20) imem_data = HALT;
      else                          imem_data = 32'h2400_0000 | {16'h0, imem_addr[15:0]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      stall = 0; jump_valid = 0; br_taken = 0;
      jump_target = 32'h0; br_target = 32'h0;
   endtask

   initial begin
      reset = 1; step = 1;
      clear_ctl();
      tick();
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'h0, id_valid}, 32'h0);
      check("rst_ins", id_ins, 32'h0);
      check("rst_pcp4", id_pcp4, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);

      reset = 0;
      tick();
      check("boot_valid", {31'h0, id_valid}, 32'h0);
      check("boot_pc", pc, 32'h0);
      tick();
      check("f0_ins", id_ins, 32'h2008_0005);
      check("f0_pcp4", id_pcp4, 32'h4);
      check("f0_pc", pc, 32'h4);
      check("f0_valid", {31'h0, id_valid}, 32'h1);
      tick();
      check("f1_pc", pc, 32'h8);
      check("f1_ins", id_ins, 32'h2400_0004);

      stall = 1;
      tick();
      tick();
      check("stall_pc", pc, 32'h8);
      check("stall_ins", id_ins, 32'h2400_0004);
      check("stall_pcp4", id_pcp4, 32'h8);
      stall = 0;
      tick();
      check("unstall_pc", pc, 32'hC);
      check("unstall_ins", id_ins, 32'h2400_0008);
      check("unstall_pcp4", id_pcp4, 32'hC);

      tick();
      check("step1_pc", pc, 32'h10);
      step = 0; br_taken = 1; br_target = 32'h100; jump_valid = 1; jump_target = 32'h200;
      #1;
      check("step0_kill", {31'h0, kill_idex}, 32'h0);
      tick();
      tick();
      check("step0_pc", pc, 32'h10);
      check("step0_ins", id_ins, 32'h2400_000C);
      check("step0_valid", {31'h0, id_valid}, 32'h1);
      clear_ctl();
      step = 1;
      tick();
      check("step_adv8_pc", pc, 32'h14);

      jump_valid = 1; jump_target = 32'h40; stall = 1; br_taken = 1; br_target = 32'h1C;
      #1;
      check("prio_kill", {31'h0, kill_idex}, 32'h1);
      tick();
      check("prio_pc", pc, 32'h1C);
      check("prio_valid", {31'h0, id_valid}, 32'h0);
      check("prio_ins", id_ins, 32'h0);
      clear_ctl();
      jump_valid = 1; jump_target = 32'h43;
      #1;
      check("jmp_kill", {31'h0, kill_idex}, 32'h0);
      tick();
      check("jmp_pc", pc, 32'h40);

      jump_target = 32'h20;
      tick();
      clear_ctl();
      check("pre_halt_pc", pc, 32'h20);
      tick();
      check("halt_ins", id_ins, HALT);
      check("halt_pcp4", id_pcp4, 32'h24);
      check("halt_valid", {31'h0, id_valid}, 32'h1);
      check("halt_flag", {31'h0, halted}, 32'h1);
      check("halt_pc", pc, 32'h20);
      tick();
      check("halted_bub_valid", {31'h0, id_valid}, 32'h0);
      check("halted_bub_pc", pc, 32'h20);
      check("halted_still", {31'h0, halted}, 32'h1);
      br_taken = 1; br_target = 32'h0;
      tick();
      clear_ctl();
      check("unhalt_flag", {31'h0, halted}, 32'h0);
      check("unhalt_pc", pc, 32'h0);

      jump_valid = 1; jump_target = 32'hFFFF_FFFC;
      tick();
      clear_ctl();
      check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      tick();
      check("wrap_pc", pc, 32'h0);
      check("wrap_pcp4", id_pcp4, 32'h0);
      check("wrap_valid", {31'h0, id_valid}, 32'h1);
      check("wrap_ins", id_ins, 32'h2400_FFFC);

      jump_valid = 1; jump_target = 32'h20;
      tick();
      clear_ctl();
      tick();
      check("rehalt_flag", {31'h0, halted}, 32'h1);

      step = 0; reset = 1;
      tick();
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_valid", {31'h0, id_valid}, 32'h0);
      check("mid_rst_halted", {31'h0, halted}, 32'h0);
      check("mid_rst_ins", id_ins, 32'h0);
`ifdef FETCH_PERF_EN
      check("perf_fetch_rst", perf_fetch, 32'h0);
      check("perf_stall_rst", perf_stall, 32'h0);
      check("perf_flush_rst", perf_flush, 32'h0);
`endif
      reset = 0; step = 1;
      tick();
      check("reboot_valid", {31'h0, id_valid}, 32'h0);
      check("reboot_pc", pc, 32'h0);
      tick();
      check("rerun_pc", pc, 32'h4);
      check("rerun_ins", id_ins, 32'h2008_0005);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
